// File: rtl/ram_pkg.sv
// Shared definitions for the self-clearing simple dual-port RAM:
// clear-sequencer state encoding and legal parameter ranges.
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    localparam int RDW_OLD_DATA = 0;
    localparam int RDW_NEW_DATA = 1;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps every address once after reset or a clr pulse,
// supplying the zero-write strobe/address and the busy flag.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    clr_state_e    state, next_state;
    logic [CW-1:0] cnt, next_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (clr) begin
                    next_state = CLEAR;
                    next_cnt   = '0;
                end
            end
            CLEAR: begin
                // clr is deliberately ignored here so a running sweep never restarts
                if (cnt == LAST) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CW'(1);
                end
            end
            default: begin
                next_state = CLEAR;
                next_cnt   = '0;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple dual-port RAM with registered, pipelined reads and an automatic
// full-memory clear after reset or on a clr pulse.
module ram_sdp_clr
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  stg_valid;
    logic [DATA_WIDTH-1:0] stg_data;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ram_clr_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clr_seq (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // The cycle that accepts clr is already a clear cycle for user traffic.
    assign wr_ok = wr_en & ~busy & ~clr;
    assign rd_ok = rd_en & ~busy & ~clr;

    // NOTE: the array has no reset; the post-reset sweep zeroes it, which keeps
    // it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= w_data;
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
        if (RDW_MODE == RDW_NEW_DATA && wr_ok && (wr_addr == rd_addr)) begin
            rd_word = w_data;
        end
    end

    generate
        if (RD_LATENCY == RD_LATENCY_MAX) begin : g_lat2
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stg_valid <= 1'b0;
                    stg_data  <= '0;
                end else begin
                    stg_valid <= rd_ok;
                    if (rd_ok) begin
                        stg_data <= rd_word;
                    end
                end
            end
        end else begin : g_lat1
            assign stg_valid = rd_ok;
            assign stg_data  = rd_word;
        end
    endgenerate

    // r_data only loads on a valid beat, so it holds between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= stg_valid;
            if (stg_valid) begin
                r_data <= stg_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: two instances (latency 1/old-data, latency 2/new-data)
// share stimulus and are compared every cycle against a word-level memory model.
module tb_ram_sdp_clr;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] w_data = '0;

    logic [DW-1:0] a_r_data, b_r_data;
    logic          a_r_valid, b_r_valid, a_busy, b_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_sdp_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .w_data(w_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .r_data(a_r_data), .r_valid(a_r_valid), .busy(a_busy)
    );

    ram_sdp_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .w_data(w_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .r_data(b_r_data), .r_valid(b_r_valid), .busy(b_busy)
    );

    // Reference model: a plain word array, a busy countdown, and per-instance
    // expected outputs (instance b sees each read one cycle later).
    logic [DW-1:0] model_mem [DEPTH];
    int            clear_left;
    logic          ea_valid, eb_valid, pend_valid;
    logic [DW-1:0] ea_data, eb_data, pend_data;

    wire [19:0] obs = {a_busy, a_r_valid, a_r_data, b_busy, b_r_valid, b_r_data};

    function automatic logic [19:0] exp_vec();
        logic bz;
        bz = (clear_left > 0);
        return {bz, ea_valid, ea_data, bz, eb_valid, eb_data};
    endfunction

    task automatic model_reset();
        clear_left = DEPTH;
        ea_valid = 1'b0; ea_data = '0;
        eb_valid = 1'b0; eb_data = '0;
        pend_valid = 1'b0; pend_data = '0;
        foreach (model_mem[i]) model_mem[i] = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input logic c, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        logic          acc, nv;
        logic [DW-1:0] old_w, new_w;
        clr = c; wr_en = we; wr_addr = wa; w_data = wd; rd_en = re; rd_addr = ra;
        @(posedge clk);
        acc   = (clear_left == 0) && !c;
        nv    = acc && re;
        old_w = model_mem[ra];
        new_w = (acc && we && wa == ra) ? wd : model_mem[ra];
        ea_valid = nv;
        if (nv) ea_data = old_w;
        eb_valid = pend_valid;
        if (pend_valid) eb_data = pend_data;
        pend_valid = nv;
        pend_data  = new_w;
        if (clear_left > 0) clear_left--;
        else if (c) begin
            clear_left = DEPTH;
            foreach (model_mem[i]) model_mem[i] = '0;
        end else if (we) model_mem[wa] = wd;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        int busy_cycles;
        #1 reset = 1'b1;
        model_reset();
        #2;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL reset_state obs=%h exp=%h", obs, exp_vec());
        end
        total++;
        @(posedge clk);
        #1 reset = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (a_busy) busy_cycles++;
            idle();
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL post_reset_clear cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
            end
            total++;
        end
        if (busy_cycles != DEPTH) begin
            bad++; $display("FAIL reset_busy_len got=%0d want=%0d", busy_cycles, DEPTH);
        end
        total++;
    endtask

    task automatic test_read_all(input string tag);
        int vcount;
        vcount = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH) step(1'b0, 1'b0, '0, '0, 1'b1, AW'(i));
            else idle();
            if (a_r_valid) vcount++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL %s cyc=%0d obs=%h exp=%h", tag, i, obs, exp_vec());
            end
            total++;
        end
        if (vcount != DEPTH) begin
            bad++; $display("FAIL %s_valid_count got=%0d want=%0d", tag, vcount, DEPTH);
        end
        total++;
    endtask

    task automatic test_write_read();
        step(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd3);
        for (int i = 0; i < 3; i++) begin
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL write_read cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
            end
            total++;
            idle();
        end
        if (a_r_data !== 8'hA5 || b_r_data !== 8'hA5) begin
            bad++; $display("FAIL write_read_data a=%h b=%h want=a5", a_r_data, b_r_data);
        end
        total++;
    endtask

    task automatic test_rdw();
        step(1'b0, 1'b1, 4'd7, 8'h11, 1'b0, '0);
        step(1'b0, 1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
        for (int i = 0; i < 3; i++) begin
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL rdw cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
            end
            total++;
            idle();
        end
        if (a_r_data !== 8'h11 || b_r_data !== 8'h3C) begin
            bad++; $display("FAIL rdw_data a=%h want=11 b=%h want=3c", a_r_data, b_r_data);
        end
        total++;
    endtask

    task automatic test_clear_blocked();
        int vcount;
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, AW'(i), DW'(i * 17 + 1), 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd5);
        // clr arrives while the read above is still in flight; wr/rd alongside are dropped
        step(1'b1, 1'b1, 4'd2, 8'h99, 1'b1, 4'd5);
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL clr_accept obs=%h exp=%h", obs, exp_vec());
        end
        total++;
        vcount = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(i == 4, 1'b1, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
                 1'b1, AW'($urandom_range(0, DEPTH - 1)));
            if (a_r_valid && a_busy) vcount++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL clear_busy cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
            end
            total++;
        end
        if (vcount != 0) begin
            bad++; $display("FAIL clear_valid_during_busy got=%0d want=0", vcount);
        end
        total++;
        idle();
        test_read_all("clear_readback");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, AW'(i), DW'(i) ^ 8'h5A, 1'b0, '0);
        test_read_all("back_to_back");
    endtask

    task automatic test_random();
        logic [AW-1:0] wa, ra;
        for (int i = 0; i < 400; i++) begin
            wa = AW'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), wa, DW'($urandom),
                 1'($urandom_range(0, 1)), ra);
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
            end
            total++;
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();
    endtask

    task automatic test_reset_mid_clear();
        int busy_cycles;
        step(1'b0, 1'b1, 4'd5, 8'h77, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd5);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 9; i++) idle();
        #2 reset = 1'b1;
        model_reset();
        #1;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL reset_mid_clear obs=%h exp=%h", obs, exp_vec());
        end
        total++;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (b_busy) busy_cycles++;
            idle();
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL reclear cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
            end
            total++;
        end
        if (busy_cycles != DEPTH) begin
            bad++; $display("FAIL reclear_busy_len got=%0d want=%0d", busy_cycles, DEPTH);
        end
        total++;
        test_read_all("reclear_readback");
    endtask

    initial begin
        test_reset();
        test_read_all("zero_after_reset");
        test_write_read();
        test_rdw();
        test_clear_blocked();
        test_back_to_back();
        test_random();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_sdp_clr.md
RAM_SDP_CLR -- requirements
Module: ram_sdp_clr

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per word, legal 1..64.
REQ-002 Parameter ADDR_WIDTH, default 8: depth = 2**ADDR_WIDTH words, legal 1..12.
REQ-003 Parameter RD_LATENCY, default 1: rd_en-to-r_valid cycles, legal 1 or 2.
REQ-004 Parameter RDW_MODE, default 0: same-address read-during-write returns old data (0) or new data (1).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 clr  input  1  one-cycle pulse that starts a full memory clear.
REQ-008 wr_en  input  1  write strobe.
REQ-009 wr_addr  input  ADDR_WIDTH  write address.
REQ-010 w_data  input  DATA_WIDTH  write data.
REQ-011 rd_en  input  1  read request.
REQ-012 rd_addr  input  ADDR_WIDTH  read address.
REQ-013 r_data  output  DATA_WIDTH  registered read data.
REQ-014 r_valid  output  1  one-cycle pulse qualifying r_data.
REQ-015 busy  output  1  high while a clear is in progress.

Function
REQ-016 FSM states: CLEAR, IDLE; reset forces CLEAR with clear counter = 0.
REQ-017 In CLEAR: write zero to address counter each cycle, counter +1; on counter = 2**ADDR_WIDTH-1 write that address, then go to IDLE next cycle.
REQ-018 A clear takes exactly 2**ADDR_WIDTH cycles; busy = 1 throughout and drops in the first IDLE cycle.
REQ-019 In IDLE, clr = 1 moves to CLEAR with counter = 0; wr_en and rd_en in that same cycle are ignored.
REQ-020 clr during CLEAR is ignored; the counter does not restart.
REQ-021 wr_en and rd_en are ignored while busy = 1; no r_valid results from them.
REQ-022 IDLE write: wr_en = 1 stores w_data at wr_addr on the rising edge.
REQ-023 IDLE read: rd_en = 1 yields r_valid = 1 with r_data = mem[rd_addr] exactly RD_LATENCY cycles later.
REQ-024 Reads are fully pipelined: back-to-back rd_en every cycle gives r_valid every cycle, in order.
REQ-025 r_data holds its last valid value when r_valid = 0.
REQ-026 Simultaneous read and write, same address, same cycle: RDW_MODE=0 returns the pre-write word; RDW_MODE=1 returns w_data.
REQ-027 Different addresses: read and write are independent, with no interaction.
REQ-028 A read already in the latency pipeline when clr is accepted still completes with its pre-clear data.
REQ-029 Address counter width is ADDR_WIDTH+1 so the terminal count does not wrap early.

Reset
REQ-030 Asynchronous reset forces r_data = 0, r_valid = 0, busy = 1, state = CLEAR, counter = 0 and flushes the read pipeline.
REQ-031 Memory array contents are not reset directly; they are zeroed by the automatic post-reset clear.
REQ-032 Reset asserted mid-clear or mid-read aborts it; after release the full clear restarts from address 0.

Structure
REQ-033 Shared package ram_pkg holds the FSM state encodings (IDLE, CLEAR) and the legal-range constants for RD_LATENCY and RDW_MODE.
REQ-034 The clear sequencer (FSM plus counter, outputs busy and the clear address/strobe) is the sub-module ram_clr_seq; the storage array and read pipeline remain in ram_sdp_clr.
REQ-035 Write-port mux: the clear sequencer has priority, driving address = counter and data = 0.

Verification
REQ-036 Release reset, DATA_WIDTH=8, ADDR_WIDTH=4 -> busy high exactly 16 cycles; then reads of addr 0..15 all return 0x00.
REQ-037 IDLE: write 0xA5 to addr 3; next cycle rd_en addr 3 -> r_valid with 0xA5 after RD_LATENCY (1 and 2 both run).
REQ-038 Same-cycle wr 0x3C / rd at addr 7 holding 0x11 -> RDW_MODE=0 returns 0x11; RDW_MODE=1 returns 0x3C.
REQ-039 Fill all addresses, pulse clr, issue wr_en/rd_en during busy -> no r_valid; after 16 cycles every address reads 0x00.
REQ-040 Read addrs 0..15 on consecutive cycles -> 16 consecutive r_valid pulses with data in address order.
REQ-041 Assert reset at clear count 9 -> outputs reset at once; after release busy lasts the full 16 cycles.
